// File: rtl/l1i_refill_unit.sv
// L1I miss handling and line fill engine.
// Takes one miss at a time, reads the line from memory beat by beat, picks a
// victim way and writes tag + data into the L1I SRAMs. Owns the per-set valid
// bits and serves them, one cycle later, to the fetch-tag stage.
module l1i_refill_unit #(
  parameter int NUM_WAYS       = 4,
  parameter int NUM_SETS       = 64,
  parameter int TAG_WIDTH      = 20,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int NUM_WARPS      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         miss_valid,
  output logic                         miss_ready,
  input  logic [TAG_WIDTH-1:0]         miss_tag,
  input  logic [$clog2(NUM_SETS)-1:0]  miss_set,
  input  logic [$clog2(NUM_WARPS)-1:0] miss_warp,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]    mem_rsp_data,
  output logic [NUM_WAYS-1:0]          tag_we,
  output logic [$clog2(NUM_SETS)-1:0]  tag_waddr,
  output logic [TAG_WIDTH-1:0]         tag_wdata,
  output logic [NUM_WAYS-1:0]          data_we,
  output logic [$clog2(NUM_SETS)-1:0]  data_waddr,
  output logic [LINE_WIDTH-1:0]        data_wdata,
  input  logic [$clog2(NUM_SETS)-1:0]  valid_rd_set,
  output logic [NUM_WAYS-1:0]          way_valid,
  input  logic                         flush,
  output logic [NUM_WARPS-1:0]         wake_warp_oh
);

  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BEATS  = LINE_WIDTH / MEM_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [SET_W-1:0]      set_q;
  logic [WARP_W-1:0]     warp_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [WAY_W-1:0]      vptr_q  [NUM_SETS];
  logic [NUM_WAYS-1:0]   way_valid_q;
  logic [NUM_WAYS-1:0]   victim_oh;
  logic                  set_full;
  logic                  in_write;

  assign in_write = (state_q == S_WRITE);

  // Victim choice: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    victim_oh = '0;
    set_full  = 1'b1;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (set_full && !valid_q[set_q][i]) begin
        victim_oh[i] = 1'b1;
        set_full     = 1'b0;
      end
    end
    if (set_full) victim_oh = NUM_WAYS'(1) << vptr_q[set_q];
  end

  // Next-state logic for the refill sequence and beat counter.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE:  if (miss_valid) state_d = S_REQ;
      S_REQ:   if (mem_req_ready) begin
                 state_d = S_FILL;
                 beat_d  = '0;
               end
      S_FILL:  if (mem_rsp_valid) begin
                 beat_d = beat_q + 1'b1;
                 if (beat_q == BEAT_W'(BEATS - 1)) state_d = S_WRITE;
               end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, valid bits, victim pointers, registered valid read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      way_valid_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      way_valid_q <= valid_q[valid_rd_set];
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      end else if (in_write) begin
        valid_q[set_q] <= valid_q[set_q] | victim_oh;
      end
      if (in_write && set_full) begin
        vptr_q[set_q] <= (vptr_q[set_q] == WAY_W'(NUM_WAYS - 1)) ? '0 : vptr_q[set_q] + 1'b1;
      end
    end
  end

  // Datapath capture: miss descriptor and incoming beats (no reset needed).
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && miss_valid) begin
      tag_q  <= miss_tag;
      set_q  <= miss_set;
      warp_q <= miss_warp;
    end
    if (state_q == S_FILL && mem_rsp_valid) begin
      line_q[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rsp_data;
    end
  end

  assign miss_ready    = (state_q == S_IDLE) && !reset;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {tag_q, set_q, {OFF_W{1'b0}}};
  assign tag_we        = in_write ? victim_oh : '0;
  assign data_we       = in_write ? victim_oh : '0;
  assign tag_waddr     = set_q;
  assign data_waddr    = set_q;
  assign tag_wdata     = tag_q;
  assign data_wdata    = line_q;
  assign way_valid     = way_valid_q;
  assign wake_warp_oh  = in_write ? (NUM_WARPS'(1) << warp_q) : '0;

endmodule

// File: tb/tb_l1i_refill_unit.sv
// Testbench for l1i_refill_unit: scoreboard of expected SRAM writes plus
// directed checks of handshakes, victim choice, flush and reset abort.
module tb_l1i_refill_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_valid;
  logic         miss_ready;
  logic [19:0]  miss_tag;
  logic [5:0]   miss_set;
  logic [1:0]   miss_warp;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic [3:0]   tag_we;
  logic [5:0]   tag_waddr;
  logic [19:0]  tag_wdata;
  logic [3:0]   data_we;
  logic [5:0]   data_waddr;
  logic [511:0] data_wdata;
  logic [5:0]   valid_rd_set;
  logic [3:0]   way_valid;
  logic         flush;
  logic [3:0]   wake_warp_oh;

  l1i_refill_unit dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_tag(miss_tag),
    .miss_set(miss_set), .miss_warp(miss_warp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .tag_we(tag_we), .tag_waddr(tag_waddr), .tag_wdata(tag_wdata),
    .data_we(data_we), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .valid_rd_set(valid_rd_set), .way_valid(way_valid),
    .flush(flush), .wake_warp_oh(wake_warp_oh)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   we;
    logic [5:0]   set;
    logic [19:0]  tag;
    logic [511:0] line;
    logic [3:0]   wake;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] m_valid [64];
  int         m_ptr   [64];
  logic [3:0] last_we;
  logic [3:0] last_wake;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference victim choice; advances the pointer only when the set is full.
  function automatic logic [3:0] model_victim(input logic [5:0] s);
    int w;
    w = 0;
    while (w < 4 && m_valid[s][w]) w++;
    if (w < 4) return 4'b0001 << w;
    w = m_ptr[s];
    m_ptr[s] = (m_ptr[s] + 1) % 4;
    return 4'b0001 << w;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[s] = 4'b0;
      m_ptr[s]   = 0;
    end
  endtask

  // Compare every SRAM write the DUT issues against the scoreboard head.
  always @(negedge clk) begin
    if (tag_we != 4'b0 || data_we != 4'b0 || wake_warp_oh != 4'b0) begin
      last_we   = tag_we;
      last_wake = wake_warp_oh;
      if (sb.size() == 0) begin
        chk("unexpected_write", {tag_we, data_we, wake_warp_oh}, 12'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tag_we",     tag_we,       e.we);
        chk("data_we",    data_we,      e.we);
        chk("tag_waddr",  tag_waddr,    e.set);
        chk("data_waddr", data_waddr,   e.set);
        chk("tag_wdata",  tag_wdata,    e.tag);
        chk("data_wdata", data_wdata,   e.line);
        chk("wake",       wake_warp_oh, e.wake);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete refill; abort_after >= 0 asserts reset after that many beats.
  task automatic do_miss(input logic [19:0] t, input logic [5:0] s, input logic [1:0] w,
                         input int gap, input int req_dly, input bit flush_wr, input int abort_after);
    int           n;
    logic [127:0] beat [4];
    exp_t         e;
    last_we   = 4'b0;
    last_wake = 4'b0;
    n = 0;
    while (!miss_ready && n < 50) begin tick(); n++; end
    chk("miss_ready_idle", miss_ready, 1'b1);
    miss_tag = t; miss_set = s; miss_warp = w; miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
    chk("req_valid", mem_req_valid, 1'b1);
    chk("req_addr", mem_req_addr, {t, s, 6'b0});
    chk("miss_ready_busy", miss_ready, 1'b0);
    for (int i = 0; i < req_dly; i++) begin
      if (i == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {4{32'hDEAD_BEEF}};
      end
      tick();
      mem_rsp_valid = 1'b0;
      chk("stall_req_valid", mem_req_valid, 1'b1);
      chk("stall_addr", mem_req_addr, {t, s, 6'b0});
      chk("stall_miss_ready", miss_ready, 1'b0);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("req_dropped", mem_req_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == abort_after) begin
        reset = 1'b1;
        #1;
        chk("abort_no_write", tag_we, 4'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        model_reset();
        return;
      end
      beat[k] = {$urandom, $urandom, $urandom, $urandom};
      if (k == 3) begin
        e.we   = model_victim(s);
        e.set  = s;
        e.tag  = t;
        e.line = {beat[3], beat[2], beat[1], beat[0]};
        e.wake = 4'b0001 << w;
        sb.push_back(e);
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = beat[k];
      tick();
      mem_rsp_valid = 1'b0;
      if (k < 3) begin
        chk("no_early_write", tag_we, 4'b0);
        for (int g = 0; g < gap; g++) tick();
      end
    end
    chk("write_after_last_beat", tag_we, e.we);
    if (flush_wr) flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("write_one_cycle", tag_we, 4'b0);
    if (flush_wr) begin
      for (int x = 0; x < 64; x++) m_valid[x] = 4'b0;
    end else begin
      m_valid[s] = m_valid[s] | e.we;
    end
  endtask

  logic [3:0] set7_exp [6];

  initial begin
    set7_exp[0] = 4'b0001; set7_exp[1] = 4'b0010; set7_exp[2] = 4'b0100;
    set7_exp[3] = 4'b1000; set7_exp[4] = 4'b0001; set7_exp[5] = 4'b0010;
    reset = 1'b1; miss_valid = 1'b0; miss_tag = '0; miss_set = '0; miss_warp = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    valid_rd_set = '0; flush = 1'b0;
    model_reset();
    tick(); tick(); tick();
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_tag_we", tag_we, 4'b0);
    chk("rst_data_we", data_we, 4'b0);
    chk("rst_wake", wake_warp_oh, 4'b0);
    chk("rst_way_valid", way_valid, 4'b0);
    reset = 1'b0;
    tick();
    chk("rst_miss_ready", miss_ready, 1'b1);

    // Basic miss: address format, first way, wake for warp 2.
    valid_rd_set = 6'd5;
    do_miss(20'h12345, 6'd5, 2'd2, 0, 0, 1'b0, -1);
    chk("basic_way", last_we, 4'b0001);
    chk("basic_wake", last_wake, 4'b0100);
    tick();
    chk("basic_way_valid", way_valid, 4'b0001);

    // Idle gaps between beats.
    do_miss(20'hABCDE, 6'd5, 2'd1, 3, 0, 1'b0, -1);
    chk("gap_way", last_we, 4'b0010);

    // Six misses to set 7: fill, then round-robin replacement.
    for (int i = 0; i < 6; i++) begin
      do_miss(20'h70000 + 20'(i), 6'd7, 2'(i), 0, 0, 1'b0, -1);
      chk("set7_way", last_we, set7_exp[i]);
    end

    // Flush during WRITE: read-before-write value, then cleared; pointer kept.
    valid_rd_set = 6'd7;
    do_miss(20'h7F00F, 6'd7, 2'd3, 0, 0, 1'b1, -1);
    chk("flush_victim", last_we, 4'b0100);
    chk("flush_wake", last_wake, 4'b1000);
    chk("flush_rbw", way_valid, 4'b1111);
    tick();
    chk("flush_way_valid", way_valid, 4'b0000);
    do_miss(20'h7F010, 6'd7, 2'd0, 0, 0, 1'b0, -1);
    chk("post_flush_way", last_we, 4'b0001);

    // Request stalled 10 cycles with a stray beat during REQ.
    do_miss(20'h0BEEF, 6'd9, 2'd0, 1, 10, 1'b0, -1);
    chk("stall_way", last_we, 4'b0001);

    // Reset after two beats, then a clean refill.
    do_miss(20'h33333, 6'd3, 2'd3, 0, 0, 1'b0, 2);
    chk("abort_miss_ready", miss_ready, 1'b1);
    do_miss(20'h44444, 6'd3, 2'd1, 0, 0, 1'b0, -1);
    chk("restart_way", last_we, 4'b0001);
    chk("restart_wake", last_wake, 4'b0010);
    valid_rd_set = 6'd7;
    tick();
    chk("reset_cleared_valid", way_valid, 4'b0000);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
